// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the dma_ctrl bus-master DMA engine.
// Optional byte-mode support is enabled with DMA_BYTE_MODE_EN.
package dma_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARB  = 3'd1,
      S_RD   = 3'd2,
      S_CAP  = 3'd3,
      S_WR   = 3'd4,
      S_DONE = 3'd5
   } dma_state_t;

   localparam logic [1:0] SEL_SRC  = 2'd0;
   localparam logic [1:0] SEL_DST  = 2'd1;
   localparam logic [1:0] SEL_CNT  = 2'd2;
   localparam logic [1:0] SEL_CTRL = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_BYTE_BIT = 1;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'h0000_8000;
   localparam logic [31:0] WORD_STRIDE     = 32'd4;
   localparam logic [31:0] BYTE_STRIDE     = 32'd1;

   function automatic logic [31:0] addr_stride(input logic byte_mode);
      return byte_mode ? BYTE_STRIDE : WORD_STRIDE;
   endfunction

endpackage

// File: rtl/dma_ctrl_if.sv
// Shared-bus signals between the DMA master and the CPU/arbiter/peripheral side.
interface dma_ctrl_if;

   logic        bus_req;
   logic        bus_grant;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;
   logic        Read;
   logic        Write;
   logic        HAL;

   modport master (
      output bus_req, address, writeData, Read, Write, HAL,
      input  bus_grant, readData
   );

   modport slave (
      input  bus_req, address, writeData, Read, Write, HAL,
      output bus_grant, readData
   );

endinterface

// File: rtl/dma_ctrl_regs.sv
// Configuration registers of dma_ctrl: CPU writes are taken only while idle, and the
// address/count registers step after every completed word. Byte mode under DMA_BYTE_MODE_EN.
module dma_ctrl_regs
   import dma_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
   parameter logic [31:0] MEM_BASE = 32'h0,
   parameter int          CNT_W    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_sel,
   input  logic [31:0] cfg_wdata,
   input  logic        idle,
   input  logic        advance,
   input  logic        clear_en,
   output logic [31:0] src,
   output logic [31:0] dst,
   output logic [31:0] src_next,
   output logic        has_work,
   output logic        last_word,
   output logic        enable,
   output logic        byte_mode
);

   logic [CNT_W-1:0] count;
   logic [31:0]      stride;
   logic [31:0]      dst_next;

   assign stride    = addr_stride(byte_mode);
   assign src_next  = src + stride;
   assign dst_next  = dst + stride;
   assign has_work  = (count != '0);
   assign last_word = (count == CNT_W'(1));

   // Writes during a transfer are dropped so the copy in flight keeps its programming
   always_ff @(posedge clk) begin
      if (reset) begin
         src    <= IO_BASE;
         dst    <= MEM_BASE;
         count  <= '0;
         enable <= 1'b0;
      end else if (idle && cfg_we) begin
         case (cfg_sel)
            SEL_SRC: src    <= cfg_wdata;
            SEL_DST: dst    <= cfg_wdata;
            SEL_CNT: count  <= cfg_wdata[CNT_W-1:0];
            default: enable <= cfg_wdata[CTRL_EN_BIT];
         endcase
      end else if (advance) begin
         src   <= src_next;
         dst   <= dst_next;
         count <= count - CNT_W'(1);
      end else if (clear_en) begin
         enable <= 1'b0;
      end
   end

`ifdef DMA_BYTE_MODE_EN
   logic byte_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_reg <= 1'b0;
      end else if (idle && cfg_we && (cfg_sel == SEL_CTRL)) begin
         byte_reg <= cfg_wdata[CTRL_BYTE_BIT];
      end
   end

   assign byte_mode = byte_reg;
`else
   assign byte_mode = 1'b0;
`endif

endmodule

// File: rtl/dma_ctrl.sv
// Bus-master DMA engine: on a peripheral request it arbitrates for the shared bus and
// copies words (or bytes with DMA_BYTE_MODE_EN) from the peripheral window to memory.
module dma_ctrl
   import dma_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
   parameter logic [31:0] MEM_BASE = 32'h0,
   parameter int          CNT_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              request_to_dma,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [31:0]       cfg_wdata,
   dma_ctrl_if.master        bus,
   output logic              busy,
   output logic              dma_done
);

   dma_state_t  state;
   logic [31:0] src;
   logic [31:0] dst;
   logic [31:0] src_next;
   logic        has_work;
   logic        last_word;
   logic        enable;
   logic        byte_mode;

   dma_ctrl_regs #(
      .IO_BASE  (IO_BASE),
      .MEM_BASE (MEM_BASE),
      .CNT_W    (CNT_W)
   ) u_regs (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_we),
      .cfg_sel   (cfg_sel),
      .cfg_wdata (cfg_wdata),
      .idle      (state == S_IDLE),
      .advance   (state == S_WR),
      .clear_en  (state == S_DONE),
      .src       (src),
      .dst       (dst),
      .src_next  (src_next),
      .has_work  (has_work),
      .last_word (last_word),
      .enable    (enable),
      .byte_mode (byte_mode)
   );

   // Bus outputs are registered, so each one is set on the edge entering the state that owns it
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         bus.bus_req   <= 1'b0;
         bus.Read      <= 1'b0;
         bus.Write     <= 1'b0;
         bus.HAL       <= 1'b0;
         bus.address   <= 32'h0;
         bus.writeData <= 32'h0;
         busy          <= 1'b0;
         dma_done      <= 1'b0;
      end else begin
         dma_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && request_to_dma && has_work) begin
                  state       <= S_ARB;
                  bus.bus_req <= 1'b1;
                  busy        <= 1'b1;
               end
            end
            S_ARB: begin
               if (bus.bus_grant) begin
                  state       <= S_RD;
                  bus.Read    <= 1'b1;
                  bus.address <= src;
                  bus.HAL     <= byte_mode;
               end
            end
            S_RD: begin
               state    <= S_CAP;
               bus.Read <= 1'b0;
               bus.HAL  <= 1'b0;
            end
            // readData arrives one cycle after the read strobe; writeData doubles as the buffer
            S_CAP: begin
               state         <= S_WR;
               bus.Write     <= 1'b1;
               bus.address   <= dst;
               bus.HAL       <= byte_mode;
               bus.writeData <= byte_mode ? {24'h0, bus.readData[7:0]} : bus.readData;
            end
            S_WR: begin
               bus.Write <= 1'b0;
               bus.HAL   <= 1'b0;
               if (last_word) begin
                  state       <= S_DONE;
                  dma_done    <= 1'b1;
                  bus.bus_req <= 1'b0;
                  busy        <= 1'b0;
               end else if (bus.bus_grant) begin
                  state       <= S_RD;
                  bus.Read    <= 1'b1;
                  bus.address <= src_next;
                  bus.HAL     <= byte_mode;
               end else begin
                  state <= S_ARB;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dma_ctrl.sv
// Self-checking bench for dma_ctrl: table-driven copies plus hand-written corner sequences.
// Byte-mode vectors are used when DMA_BYTE_MODE_EN is defined.
module tb_dma_ctrl;
   import dma_ctrl_pkg::*;

   localparam int NUM_CASES = 4;

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          cnt;
      logic [31:0] ctrl;
      int          delay;
      int          first;
      logic        hal;
   } case_t;

   typedef struct {
      logic [31:0] rd_addr;
      logic [31:0] wr_addr;
      logic [31:0] wr_data;
   } word_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        request_to_dma = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_sel = 2'd0;
   logic [31:0] cfg_wdata = 32'h0;
   logic        busy;
   logic        dma_done;

   int checks = 0;
   int errors = 0;

   logic [31:0] rd_addr_q[$];
   logic        rd_hal_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic        wr_hal_q[$];
   int          done_cnt = 0;
   int          overlap_cnt = 0;

   case_t       cases[NUM_CASES];
   word_t       words[11];
   logic [31:0] ctrl_en;
   logic [31:0] ctrl_byte;

   dma_ctrl_if bus();

   dma_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .request_to_dma (request_to_dma),
      .cfg_we         (cfg_we),
      .cfg_sel        (cfg_sel),
      .cfg_wdata      (cfg_wdata),
      .bus            (bus),
      .busy           (busy),
      .dma_done       (dma_done)
   );

   always #5 clk = ~clk;

   // Peripheral/memory model: read data is the address plus 0xA0, one cycle after Read
   always @(posedge clk) begin
      bus.readData <= bus.Read ? bus.address + 32'hA0 : 32'h0;
   end

   always @(negedge clk) begin
      if (bus.Read && bus.Write) overlap_cnt++;
      if (bus.Read) begin
         rd_addr_q.push_back(bus.address);
         rd_hal_q.push_back(bus.HAL);
      end
      if (bus.Write) begin
         wr_addr_q.push_back(bus.address);
         wr_data_q.push_back(bus.writeData);
         wr_hal_q.push_back(bus.HAL);
      end
      if (dma_done) done_cnt++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
      cfg_we    = 1'b1;
      cfg_sel   = sel;
      cfg_wdata = data;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst,
                                input int cnt, input logic [31:0] ctrl);
      cfg_write(SEL_SRC, src);
      cfg_write(SEL_DST, dst);
      cfg_write(SEL_CNT, 32'(cnt));
      cfg_write(SEL_CTRL, ctrl);
      request_to_dma = 1'b1;
   endtask

   function automatic logic sig_val(input int which);
      case (which)
         0:       return bus.bus_req;
         1:       return bus.Read;
         2:       return bus.Write;
         default: return dma_done;
      endcase
   endfunction

   task automatic wait_signal(input string name, input int which, input int limit);
      int n = 0;
      while (!sig_val(which) && n < limit) begin
         tick();
         n++;
      end
      checkOutput({name, " seen in time"}, 32'(n < limit), 32'd1);
   endtask

   // Waits for bus_req, holds off the grant, then grants and waits for completion
   task automatic run_transfer(input int delay, input string tag,
                               output int rb, output int wb, output int db);
      wait_signal({tag, " bus_req"}, 0, 10);
      rb = rd_addr_q.size();
      wb = wr_addr_q.size();
      db = done_cnt;
      tick(delay);
      checkOutput({tag, " no access before grant"},
                  32'(rd_addr_q.size() + wr_addr_q.size() - rb - wb), 32'd0);
      bus.bus_grant = 1'b1;
      tick();
      checkOutput({tag, " Read after grant"}, 32'(bus.Read), 32'd1);
      wait_signal({tag, " dma_done"}, 3, 200);
      checkOutput({tag, " busy in done"}, 32'(busy), 32'd0);
      tick();
      checkOutput({tag, " done pulse width"}, 32'(dma_done), 32'd0);
      bus.bus_grant  = 1'b0;
      request_to_dma = 1'b0;
      tick();
   endtask

   initial begin
      int    rb, wb, db;
      word_t exp_w;
      string tag;

      bus.bus_grant = 1'b0;
      ctrl_en   = 32'd1 << CTRL_EN_BIT;
      ctrl_byte = ctrl_en | (32'd1 << CTRL_BYTE_BIT);

      cases[0] = '{32'h0000_8000, 32'h0000_0100, 3, ctrl_en, 0, 0, 1'b0};
      cases[1] = '{32'hFFFF_FFFC, 32'h0000_0200, 2, ctrl_en, 5, 3, 1'b0};
      cases[2] = '{32'h0000_9000, 32'hFFFF_FFFC, 2, ctrl_en, 2, 5, 1'b0};
      words[0] = '{32'h0000_8000, 32'h0000_0100, 32'h0000_80A0};
      words[1] = '{32'h0000_8004, 32'h0000_0104, 32'h0000_80A4};
      words[2] = '{32'h0000_8008, 32'h0000_0108, 32'h0000_80A8};
      words[3] = '{32'hFFFF_FFFC, 32'h0000_0200, 32'h0000_009C};
      words[4] = '{32'h0000_0000, 32'h0000_0204, 32'h0000_00A0};
      words[5] = '{32'h0000_9000, 32'hFFFF_FFFC, 32'h0000_90A0};
      words[6] = '{32'h0000_9004, 32'h0000_0000, 32'h0000_90A4};
`ifdef DMA_BYTE_MODE_EN
      cases[3]  = '{32'h0000_8000, 32'h0000_0800, 4, ctrl_byte, 0, 7, 1'b1};
      words[7]  = '{32'h0000_8000, 32'h0000_0800, 32'h0000_00A0};
      words[8]  = '{32'h0000_8001, 32'h0000_0801, 32'h0000_00A1};
      words[9]  = '{32'h0000_8002, 32'h0000_0802, 32'h0000_00A2};
      words[10] = '{32'h0000_8003, 32'h0000_0803, 32'h0000_00A3};
`else
      cases[3]  = '{32'h0000_8000, 32'h0000_0240, 2, ctrl_byte, 0, 7, 1'b0};
      words[7]  = '{32'h0000_8000, 32'h0000_0240, 32'h0000_80A0};
      words[8]  = '{32'h0000_8004, 32'h0000_0244, 32'h0000_80A4};
      words[9]  = '{32'h0, 32'h0, 32'h0};
      words[10] = '{32'h0, 32'h0, 32'h0};
`endif

      $display("[TB] reset state");
      tick(2);
      checkOutput("reset flags", 32'({bus.bus_req, bus.Read, bus.Write, bus.HAL, busy, dma_done}), 32'd0);
      checkOutput("reset address", bus.address, 32'h0);
      checkOutput("reset writeData", bus.writeData, 32'h0);
      reset = 1'b0;
      tick();

      $display("[TB] table-driven copies");
      for (int c = 0; c < NUM_CASES; c++) begin
         tag = $sformatf("case%0d", c);
         applyStimulus(cases[c].src, cases[c].dst, cases[c].cnt, cases[c].ctrl);
         run_transfer(cases[c].delay, tag, rb, wb, db);
         checkOutput({tag, " read count"}, 32'(rd_addr_q.size() - rb), 32'(cases[c].cnt));
         checkOutput({tag, " write count"}, 32'(wr_addr_q.size() - wb), 32'(cases[c].cnt));
         checkOutput({tag, " done count"}, 32'(done_cnt - db), 32'd1);
         for (int w = 0; w < cases[c].cnt; w++) begin
            exp_w = words[cases[c].first + w];
            if (rb + w < rd_addr_q.size()) begin
               checkOutput($sformatf("%s rd addr %0d", tag, w), rd_addr_q[rb + w], exp_w.rd_addr);
               checkOutput($sformatf("%s rd HAL %0d", tag, w), 32'(rd_hal_q[rb + w]), 32'(cases[c].hal));
            end
            if (wb + w < wr_addr_q.size()) begin
               checkOutput($sformatf("%s wr addr %0d", tag, w), wr_addr_q[wb + w], exp_w.wr_addr);
               checkOutput($sformatf("%s wr data %0d", tag, w), wr_data_q[wb + w], exp_w.wr_data);
               checkOutput($sformatf("%s wr HAL %0d", tag, w), 32'(wr_hal_q[wb + w]), 32'(cases[c].hal));
            end
         end
      end

      $display("[TB] preemption between words");
      applyStimulus(32'h0000_8000, 32'h0000_0300, 2, ctrl_en);
      wait_signal("preempt bus_req", 0, 10);
      rb = rd_addr_q.size();
      wb = wr_addr_q.size();
      bus.bus_grant = 1'b1;
      wait_signal("preempt first write", 2, 20);
      bus.bus_grant = 1'b0;
      tick(4);
      checkOutput("preempt reads while parked", 32'(rd_addr_q.size() - rb), 32'd1);
      checkOutput("preempt bus_req held", 32'(bus.bus_req), 32'd1);
      checkOutput("preempt busy held", 32'(busy), 32'd1);
      bus.bus_grant = 1'b1;
      wait_signal("preempt dma_done", 3, 50);
      tick();
      bus.bus_grant  = 1'b0;
      request_to_dma = 1'b0;
      tick();
      checkOutput("preempt word1 wr addr", wr_addr_q[wb], 32'h0000_0300);
      checkOutput("preempt word2 rd addr", rd_addr_q[rb + 1], 32'h0000_8004);
      checkOutput("preempt word2 wr addr", wr_addr_q[wb + 1], 32'h0000_0304);
      checkOutput("preempt word2 wr data", wr_data_q[wb + 1], 32'h0000_80A4);

      $display("[TB] config lockout");
      applyStimulus(32'h0000_8000, 32'h0000_0400, 2, ctrl_en);
      wait_signal("lock bus_req", 0, 10);
      wb = wr_addr_q.size();
      cfg_write(SEL_DST, 32'h0000_0500);
      cfg_write(SEL_CNT, 32'd5);
      bus.bus_grant = 1'b1;
      wait_signal("lock dma_done", 3, 100);
      tick();
      bus.bus_grant  = 1'b0;
      request_to_dma = 1'b0;
      tick();
      checkOutput("lock write count", 32'(wr_addr_q.size() - wb), 32'd2);
      checkOutput("lock wr addr 0", wr_addr_q[wb], 32'h0000_0400);
      checkOutput("lock wr addr 1", wr_addr_q[wb + 1], 32'h0000_0404);
      request_to_dma = 1'b1;
      tick(5);
      checkOutput("enable cleared after done", 32'(bus.bus_req), 32'd0);
      cfg_write(SEL_DST, 32'h0000_0500);
      cfg_write(SEL_CNT, 32'd1);
      cfg_write(SEL_CTRL, ctrl_en);
      run_transfer(0, "relock", rb, wb, db);
      checkOutput("relock rd addr", rd_addr_q[rb], 32'h0000_8008);
      checkOutput("relock wr addr", wr_addr_q[wb], 32'h0000_0500);

      $display("[TB] zero count");
      cfg_write(SEL_SRC, 32'h0000_A000);
      cfg_write(SEL_CNT, 32'd0);
      cfg_write(SEL_CTRL, ctrl_en);
      request_to_dma = 1'b1;
      tick(5);
      checkOutput("count0 bus_req", 32'(bus.bus_req), 32'd0);
      checkOutput("count0 busy", 32'(busy), 32'd0);
      cfg_write(SEL_CNT, 32'd1);
      run_transfer(0, "count0 kept enable", rb, wb, db);
      checkOutput("count0 rd addr", rd_addr_q[rb], 32'h0000_A000);
      checkOutput("count0 wr addr", wr_addr_q[wb], 32'h0000_0504);

      $display("[TB] reset mid-transfer");
      applyStimulus(32'h0000_8800, 32'h0000_0600, 3, ctrl_en);
      wait_signal("abort bus_req", 0, 10);
      db = done_cnt;
      bus.bus_grant = 1'b1;
      wait_signal("abort read", 1, 20);
      tick();
      checkOutput("abort in capture", 32'({bus.Read, bus.Write}), 32'd0);
      reset = 1'b1;
      tick();
      checkOutput("abort flags", 32'({bus.bus_req, bus.Read, bus.Write, bus.HAL, busy, dma_done}), 32'd0);
      checkOutput("abort address", bus.address, 32'h0);
      checkOutput("abort writeData", bus.writeData, 32'h0);
      reset          = 1'b0;
      bus.bus_grant  = 1'b0;
      request_to_dma = 1'b0;
      tick(5);
      checkOutput("abort no dma_done", 32'(done_cnt - db), 32'd0);
      cfg_write(SEL_DST, 32'h0000_0700);
      cfg_write(SEL_CNT, 32'd1);
      cfg_write(SEL_CTRL, ctrl_en);
      request_to_dma = 1'b1;
      run_transfer(0, "post-reset", rb, wb, db);
      checkOutput("post-reset src", rd_addr_q[rb], 32'h0000_8000);
      checkOutput("post-reset wr addr", wr_addr_q[wb], 32'h0000_0700);
      checkOutput("post-reset wr data", wr_data_q[wb], 32'h0000_80A0);

      checkOutput("Read/Write overlap cycles", 32'(overlap_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_ctrl.md
Name: dma_ctrl

Overview:
- Bus-master DMA engine on the other end of a peripheral's `request_to_dma` line (keyboard io block at 0x8000).
- On an asserted request it requests the shared CPU bus. It copies a programmed number of words from the peripheral window into data memory using the same Read/Write/HAL/address bus signalling the peripherals decode.
- It pulses an interrupt to the CPU when the copy is finished.

Parameters:
- IO_BASE, 32768, reset value of the source address register (peripheral window base).
- MEM_BASE, 0, reset value of the destination address register.
- CNT_W, 8, width of the transfer word counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- request_to_dma  in  1  level request from peripheral
- cfg_we  in  1  CPU configuration write strobe
- cfg_sel  in  2  0=src addr, 1=dst addr, 2=count, 3=control (bit0 enable)
- cfg_wdata  in  32  configuration data
- bus_req  out  1  request for shared bus
- bus_grant  in  1  bus granted by CPU/arbiter
- address  out  32  bus address
- writeData  out  32  bus write data
- readData  in  32  bus read data
- Read  out  1  read strobe
- Write  out  1  write strobe
- HAL  out  1  byte-access select
- busy  out  1  transfer in progress
- dma_done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - Registers: src=IO_BASE, dst=MEM_BASE, count=0, enable=0.
  - Outputs: bus_req=0, Read=0, Write=0, HAL=0, address=0, writeData=0, busy=0, dma_done=0.
  - FSM returns to IDLE.
- Config writes are accepted only in IDLE; writes during a transfer are ignored.
- FSM states: IDLE, ARB, RD, CAP, WR, DONE.
- IDLE → ARB: when enable=1, request_to_dma=1 and count≠0. bus_req=1 and busy=1 from ARB onward.
- ARB: wait for bus_grant. No timeout; bus outputs stay inactive (Read=Write=0).
- RD: address=src, Read=1, Write=0, for exactly one cycle.
- CAP: Read=0; latch readData into data buffer. One cycle after RD, so read latency is 1 cycle.
- WR: address=dst, writeData=buffer, Write=1, Read=0, for one cycle. At exit: src+=4, dst+=4, count−=1.
- After WR:
  - count(after decrement)=0 → DONE.
  - Otherwise, if bus_grant=1 → RD; if bus_grant=0 → ARB (preemption between words, never mid-word).
- DONE: dma_done=1 for one cycle; bus_req=0, busy=0, enable cleared → IDLE.
- Read and Write are never both 1 in the same cycle.
- Addresses wrap modulo 2^32. Count is unsigned CNT_W.
- If request_to_dma deasserts mid-transfer, the transfer still completes the programmed count.
- bus_grant dropping during RD/CAP/WR is ignored until the word completes.
- Reset asserted in any state returns everything to reset values on the next edge; the transfer is aborted with no dma_done.
- count=0 with enable=1: no transfer; enable stays set.

Optional Feature:
- Macro: DMA_BYTE_MODE_EN.
- Defined: control bit1 selects byte mode.
  - HAL=1 during RD and WR.
  - src and dst increment by 1 per transfer; count counts bytes.
  - writeData carries the byte in [7:0], zero-extended.
- Undefined: control bit1 is ignored, HAL is tied to 0, word mode only.

Decomposition:
- Shared package:
  - FSM state encoding (3-bit).
  - cfg_sel codes.
  - Control bit positions.
  - IO_BASE default 32'h8000.
  - Word stride constant 4.
- Sub-module dma_regs: configuration register file, including the write gating to IDLE and the next-state update of src/dst/count. The FSM stays in dma_ctrl.

Test Plan:
- Basic copy:
  - Stimulus: program src=0x8000, dst=0x100, count=3, enable=1; assert request_to_dma; grant in the cycle after bus_req. Bus model returns readData=0xA0+addr.
  - Required: 3 RD/WR pairs to 0x8000/0x100, 0x8004/0x104, 0x8008/0x108 with matching data; dma_done pulse 1 cycle; busy=0 after.
- Grant delay:
  - Stimulus: hold bus_grant=0 for 5 cycles after bus_req.
  - Required: no Read/Write until the grant; first RD on the cycle after grant is seen.
- Preemption:
  - Stimulus: drop bus_grant during the WR of word 1 of 2.
  - Required: word 1 completes; FSM waits in ARB; word 2 resumes at src+4 after re-grant.
- Reset mid-transfer:
  - Stimulus: assert reset in the CAP state.
  - Required: next edge gives all outputs at reset values, src=0x8000, no dma_done.
- Config lockout:
  - Stimulus: cfg write dst=0x500 while busy.
  - Required: destination sequence unchanged. After DONE, the same write is accepted.
- Byte mode (DMA_BYTE_MODE_EN defined):
  - Stimulus: count=4, byte bit set.
  - Required: HAL=1; addresses 0x8000..0x8003 and dst..dst+3.
